lsq_station: RTL

LSQ_STATION -- requirements
Module: lsq_station

---
 rtl/lsq_station.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/lsq_station.sv
// In-order load/store station: tagged operand capture, age FIFO, single memory port.
// Ports: alloc_* entry write, bc_* CDB snoop, breq/bc_*_out result broadcast,
//        mem_* memory port, busy per-entry occupancy. Option macro: LSQ_IMM_SEXT_EN.
module lsq_station #(
  parameter int unsigned         DEPTH    = 4,
  parameter int unsigned         DW       = 32,
  parameter int unsigned         TW       = 5,
  parameter int unsigned         AW       = 9,
  parameter logic [TW-1:0]       TAG_BASE = 5'd8
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic [TW-1:0]    alloc_tag,
  input  logic [3:0]       alloc_op,
  input  logic [DW-1:0]    alloc_v1,
  input  logic [DW-1:0]    alloc_v2,
  input  logic [TW-1:0]    alloc_q1,
  input  logic [TW-1:0]    alloc_q2,
  input  logic [15:0]      alloc_imm,
  output logic [DEPTH-1:0] busy,
  input  logic             bc_en,
  input  logic [TW-1:0]    bc_tag,
  input  logic [DW-1:0]    bc_data,
  output logic             breq,
  input  logic             breq_ack,
  output logic [TW-1:0]    bc_tag_out,
  output logic [DW-1:0]    bc_data_out,
  output logic             mem_wen,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BC
  } state_t;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DEPTH-1:0] st_q, st_d;
  logic [DW-1:0]    v1_q [DEPTH];
  logic [DW-1:0]    v1_d [DEPTH];
  logic [DW-1:0]    v2_q [DEPTH];
  logic [DW-1:0]    v2_d [DEPTH];
  logic [TW-1:0]    q1_q [DEPTH];
  logic [TW-1:0]    q1_d [DEPTH];
  logic [TW-1:0]    q2_q [DEPTH];
  logic [TW-1:0]    q2_d [DEPTH];
  logic [15:0]      imm_q [DEPTH];
  logic [15:0]      imm_d [DEPTH];

  logic [IW-1:0]    fifo_q [DEPTH];
  logic [IW-1:0]    hd_q, tl_q;
  logic [CW-1:0]    cnt_q;

  state_t           state_q;
  logic             breq_q;
  logic [TW-1:0]    btag_q;
  logic [DW-1:0]    bdata_q;
  logic             wen_q;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    wdata_q;

  logic             bcv;
  logic             aval;
  logic [IW-1:0]    aidx;
  logic             push;
  logic             pop;
  logic [IW-1:0]    hidx;
  logic             head_rdy;
  logic [DW-1:0]    imm_ext;
  logic [DW-1:0]    sum;
  logic             unused_ok;

  assign bcv = bc_en && (bc_tag != '0);

  always_comb begin
    aval = 1'b0;
    aidx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc_tag == TAG_BASE + TW'(i)) begin
        aval = 1'b1;
        aidx = IW'(i);
      end
    end
  end

  // Each busy entry sits in the FIFO exactly once, so push never overflows.
  assign push = aval && !busy_q[aidx];
  assign hidx = fifo_q[hd_q];

  assign head_rdy = (cnt_q != '0) && (q1_q[hidx] == '0) &&
                    (!st_q[hidx] || (q2_q[hidx] == '0));

  assign pop = ((state_q == ISSUE) && st_q[hidx]) ||
               ((state_q == WAIT_BC) && breq_ack);

`ifdef LSQ_IMM_SEXT_EN
  assign imm_ext = {{(DW-16){imm_q[hidx][15]}}, imm_q[hidx]};
`else
  assign imm_ext = {{(DW-16){1'b0}}, imm_q[hidx]};
`endif

  assign sum = v1_q[hidx] + imm_ext;

  assign unused_ok = ^{sum[DW-1:AW], alloc_op[2:0]};

  always_comb begin
    busy_d = busy_q;
    st_d   = st_q;
    v1_d   = v1_q;
    v2_d   = v2_q;
    q1_d   = q1_q;
    q2_d   = q2_q;
    imm_d  = imm_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (busy_q[i] && bcv) begin
        if (q1_q[i] == bc_tag) begin
          q1_d[i] = '0;
          v1_d[i] = bc_data;
        end
        if (q2_q[i] == bc_tag) begin
          q2_d[i] = '0;
          v2_d[i] = bc_data;
        end
      end
      if (pop && (hidx == IW'(i))) begin
        busy_d[i] = 1'b0;
      end
      // New entry snoops the bus in its allocation cycle.
      if (push && (aidx == IW'(i))) begin
        busy_d[i] = 1'b1;
        st_d[i]   = alloc_op[3];
        imm_d[i]  = alloc_imm;
        if (bcv && (alloc_q1 == bc_tag)) begin
          q1_d[i] = '0;
          v1_d[i] = bc_data;
        end else begin
          q1_d[i] = alloc_q1;
          v1_d[i] = alloc_v1;
        end
        if (bcv && (alloc_q2 == bc_tag)) begin
          q2_d[i] = '0;
          v2_d[i] = bc_data;
        end else begin
          q2_d[i] = alloc_q2;
          v2_d[i] = alloc_v2;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      busy_q <= '0;
      st_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        v1_q[i]  <= '0;
        v2_q[i]  <= '0;
        q1_q[i]  <= '0;
        q2_q[i]  <= '0;
        imm_q[i] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      st_q   <= st_d;
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      q1_q   <= q1_d;
      q2_q   <= q2_d;
      imm_q  <= imm_d;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      hd_q  <= '0;
      tl_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_q[tl_q] <= aidx;
        tl_q <= (tl_q == IW'(DEPTH-1)) ? '0 : tl_q + IW'(1);
      end
      if (pop) begin
        hd_q <= (hd_q == IW'(DEPTH-1)) ? '0 : hd_q + IW'(1);
      end
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Memory outputs are loaded on entry to ISSUE so they are valid
  // for exactly the ISSUE cycle; the write commits at its closing edge.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      breq_q  <= 1'b0;
      btag_q  <= '0;
      bdata_q <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (head_rdy) begin
            state_q <= ISSUE;
            wen_q   <= st_q[hidx];
            addr_q  <= sum[AW-1:0];
            wdata_q <= v2_q[hidx];
          end
        end
        ISSUE: begin
          wen_q   <= 1'b0;
          addr_q  <= '0;
          wdata_q <= '0;
          if (st_q[hidx]) begin
            state_q <= IDLE;
          end else begin
            state_q <= WAIT_BC;
            breq_q  <= 1'b1;
            btag_q  <= TAG_BASE + TW'(hidx);
            bdata_q <= mem_rdata;
          end
        end
        WAIT_BC: begin
          if (breq_ack) begin
            state_q <= IDLE;
            breq_q  <= 1'b0;
            btag_q  <= '0;
            bdata_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign breq        = breq_q;
  assign bc_tag_out  = btag_q;
  assign bc_data_out = bdata_q;
  assign mem_wen     = wen_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;

endmodule
